// File: rtl/console_uart_tx.sv
// console_uart_tx: FIFO-buffered UART transmitter for the keyboard-to-host path.
// Data width, parity mode, stop-bit count and buffer depth are parameters.
module console_uart_tx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int DEPTH        = 16
) (
    input  logic                     clk100M,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [DATA_BITS-1:0]     wr_data,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    input  logic                     clr_overflow,
    output logic                     busy,
    output logic                     uartTx
);
    localparam int AW = $clog2(DEPTH);
    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [TW-1:0] T_RELOAD = TW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] B_LAST   = BW'(DATA_BITS - 1);
    localparam logic          S_LAST   = 1'(STOP_BITS - 1);
    localparam logic [AW:0]   C_FULL   = (AW + 1)'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    logic [DATA_BITS-1:0] mem_q [DEPTH];
    logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [AW:0]          count_q, count_d;
    logic                 full_q, full_d;
    logic                 ovf_q, ovf_d;
    state_t               state_q, state_d;
    logic [TW-1:0]        tmr_q, tmr_d;
    logic [BW-1:0]        bit_q, bit_d;
    logic                 stp_q, stp_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_q, par_d;
    logic                 tx_q, tx_d;
    logic                 push;
    logic                 pop;
    logic [DATA_BITS-1:0] head;
    logic                 head_par;

    assign push     = wr_en & ~full_q;
    assign head     = mem_q[rd_ptr_q];
    assign head_par = (PARITY == 2) ? ~(^head) : (^head);

    // FIFO pointer, occupancy and sticky overflow next-state
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        unique case ({push, pop})
            2'b10:   count_d = count_q + (AW + 1)'(1);
            2'b01:   count_d = count_q - (AW + 1)'(1);
            default: count_d = count_q;
        endcase
        full_d = (count_d == C_FULL);
        if (clr_overflow)    ovf_d = 1'b0;
        if (wr_en && full_q) ovf_d = 1'b1;
    end

    // Serialiser FSM: bit timing, pops and the registered line level
    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        bit_d   = bit_q;
        stp_d   = stp_q;
        shift_d = shift_q;
        par_d   = par_q;
        pop     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (count_q != '0) begin
                    pop     = 1'b1;
                    shift_d = head;
                    par_d   = head_par;
                    tmr_d   = T_RELOAD;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (tmr_q == '0) begin
                    tmr_d   = T_RELOAD;
                    bit_d   = '0;
                    state_d = S_DATA;
                end else begin
                    tmr_d = tmr_q - TW'(1);
                end
            end
            S_DATA: begin
                if (tmr_q == '0) begin
                    tmr_d = T_RELOAD;
                    if (bit_q == B_LAST) begin
                        stp_d   = 1'b0;
                        state_d = (PARITY != 0) ? S_PARITY : S_STOP;
                    end else begin
                        bit_d   = bit_q + BW'(1);
                        shift_d = shift_q >> 1;
                    end
                end else begin
                    tmr_d = tmr_q - TW'(1);
                end
            end
            S_PARITY: begin
                if (tmr_q == '0) begin
                    tmr_d   = T_RELOAD;
                    stp_d   = 1'b0;
                    state_d = S_STOP;
                end else begin
                    tmr_d = tmr_q - TW'(1);
                end
            end
            S_STOP: begin
                if (tmr_q == '0) begin
                    tmr_d = T_RELOAD;
                    if (stp_q == S_LAST) begin
                        if (count_q != '0) begin
                            pop     = 1'b1;
                            shift_d = head;
                            par_d   = head_par;
                            state_d = S_START;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        stp_d = 1'b1;
                    end
                end else begin
                    tmr_d = tmr_q - TW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
        unique case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shift_d[0];
            S_PARITY: tx_d = par_d;
            default:  tx_d = 1'b1;
        endcase
    end

    // State registers with synchronous reset
    always_ff @(posedge clk100M) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            ovf_q    <= 1'b0;
            state_q  <= S_IDLE;
            tmr_q    <= '0;
            bit_q    <= '0;
            stp_q    <= 1'b0;
            shift_q  <= '0;
            par_q    <= 1'b0;
            tx_q     <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            ovf_q    <= ovf_d;
            state_q  <= state_d;
            tmr_q    <= tmr_d;
            bit_q    <= bit_d;
            stp_q    <= stp_d;
            shift_q  <= shift_d;
            par_q    <= par_d;
            tx_q     <= tx_d;
        end
    end

    // FIFO storage, written only on an accepted push
    always_ff @(posedge clk100M) begin
        if (push) mem_q[wr_ptr_q] <= wr_data;
    end

    assign full     = full_q;
    assign count    = count_q;
    assign overflow = ovf_q;
    assign busy     = (state_q != S_IDLE);
    assign uartTx   = tx_q;
endmodule
